// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file for the decode stage.
// - XLEN-bit registers, DEPTH = 2**ADDR_W entries, NUM_RD combinational read ports.
// - Register 0 reads as zero and is never written.
// - After reset, a CLEAR sweep zeroes registers 1..DEPTH-1, then `ready` rises.
// - Optional macro REG_FILE_BYPASS_EN: a write in flight is forwarded to any read
//   port addressing the same register in the same cycle.
//   The default build (macro undefined) shows the pre-edge stored value instead.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs,
  output logic [NUM_RD*XLEN-1:0]   rs_d,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [XLEN-1:0]          rd_d,
  input  logic                     reg_wr,
  output logic                     ready
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  // DEPTH is a power of two, so the last index is all ones.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;

  // Single array write port.
  // It is shared between the clear sweep and user writes; the two never
  // overlap because user writes are only honoured in RUN.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN-1:0]     mem_q [DEPTH];

  // A user write that will actually commit at the next edge.
  // Writes to register 0 and writes during the sweep are dropped, not queued.
  logic                user_wr;

  assign user_wr = (state_q == RUN) && reg_wr && (rd != '0);

  // Next-state logic for the sweep FSM and selection of the array write source.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = rd;
    mem_wdata = rd_d;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        mem_we  = user_wr;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = FIRST_IDX;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous active-low reset.
  // Reset restarts the sweep at register 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST_IDX;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Register array write.
  // The array has no reset of its own; the sweep clears it instead.
  // Nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready = ready_q;

  // Independent combinational read ports.
  // Each port is zero during the sweep and when it addresses register 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   data;

      assign addr = rs[gi*ADDR_W +: ADDR_W];

      // Select stored data, or forwarded write data when bypass is enabled.
      always_comb begin
        data = '0;
        if ((state_q == RUN) && (addr != '0)) begin
          data = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
          if (user_wr && (addr == rd)) begin
            data = rd_d;
          end
`endif
        end
      end

      assign rs_d[gi*XLEN +: XLEN] = data;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp.
// Two instances are driven side by side:
// - u_a uses the default parameters.
// - u_b uses XLEN=16, ADDR_W=3, NUM_RD=4.
// Stimulus pushes expected values into a scoreboard queue.
// A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [9:0]  rs_a;
  logic [63:0] rs_d_a;
  logic [4:0]  rd_a;
  logic [31:0] rd_d_a;
  logic        wr_a;
  logic        ready_a;

  logic [11:0] rs_b;
  logic [63:0] rs_d_b;
  logic [2:0]  rd_b;
  logic [15:0] rd_d_b;
  logic        wr_b;
  logic        ready_b;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .rs(rs_a), .rs_d(rs_d_a),
    .rd(rd_a), .rd_d(rd_d_a), .reg_wr(wr_a), .ready(ready_a)
  );

  reg_file_mp #(.XLEN(16), .ADDR_W(3), .NUM_RD(4)) u_b (
    .clk(clk), .rst_n(rst_n), .rs(rs_b), .rs_d(rs_d_b),
    .rd(rd_b), .rd_d(rd_d_b), .reg_wr(wr_b), .ready(ready_b)
  );

  // Scoreboard entry kinds:
  // 0 = ready of u_a, 1 = u_a read port, 2 = ready of u_b, 3 = u_b read port.
  typedef struct {
    int          kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic push(input int kind, input int port, input logic [63:0] v, input string n);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    sb_q.push_back(e);
    nm_q.push_back(n);
  endtask

  // Advance past a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let the monitor consume everything queued so far.
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare every pending expectation against the outputs now present.
  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [63:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      act = '0;
      case (e.kind)
        0: act = {63'b0, ready_a};
        1: act = {32'b0, rs_d_a[e.port*32 +: 32]};
        2: act = {63'b0, ready_b};
        default: act = {48'b0, rs_d_b[e.port*16 +: 16]};
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_miss++;
        $display("FAIL %s: got %h, expected %h", nm, act, e.exp);
      end else begin
        $display("ok   %s: %h", nm, act);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    rs_a   = '0; rd_a = '0; rd_d_a = '0; wr_a = 1'b0;
    rs_b   = '0; rd_b = '0; rd_d_b = '0; wr_b = 1'b0;

    // Reset for two edges, then sweep while attempting writes to r2.
    step();
    step();
    rst_n  = 1'b1;
    wr_a   = 1'b1; rd_a = 5'd2; rd_d_a = 32'hA5A5A5A5;
    rs_a   = {5'd2, 5'h1F};
    push(0, 0, 64'd0, "a_ready_after_reset");
    push(1, 0, 64'd0, "a_rs1F_in_clear");
    push(1, 1, 64'd0, "a_rs2_in_clear");
    push(2, 0, 64'd0, "b_ready_after_reset");
    sample();

    for (int i = 1; i <= 31; i++) begin
      step();
      push(0, 0, (i == 31) ? 64'd1 : 64'd0, $sformatf("a_ready_sweep_edge%0d", i));
      if (i < 31) push(1, 1, 64'd0, $sformatf("a_rs2_zero_edge%0d", i));
      push(2, 0, (i >= 7) ? 64'd1 : 64'd0, $sformatf("b_ready_sweep_edge%0d", i));
      sample();
    end
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_miss++;
      $display("FAIL direct_ready_after_sweep: got a=%b b=%b, expected 1 1", ready_a, ready_b);
    end else begin
      $display("ok   direct_ready_after_sweep: a=%b b=%b", ready_a, ready_b);
    end
    wr_a = 1'b0;
    rs_a = {5'd0, 5'h1F};
    push(1, 0, 64'd0, "a_rs1F_after_sweep");
    sample();
    rs_a = {5'd0, 5'd2};
    push(1, 0, 64'd0, "a_r2_not_written_in_clear");
    sample();

    // Write/read: r1=1, r3=2.
    wr_a = 1'b1; rd_a = 5'd1; rd_d_a = 32'h00000001;
    step();
    rd_a = 5'd3; rd_d_a = 32'h00000002;
    step();
    wr_a = 1'b0;
    rs_a = {5'd3, 5'd1};
    push(1, 0, 64'h1, "a_read_r1");
    push(1, 1, 64'h2, "a_read_r3");
    sample();
    if (rs_d_a !== {32'h00000002, 32'h00000001}) begin
      n_miss++;
      $display("FAIL direct_read_r3_r1: got %h, expected %h", rs_d_a, {32'h00000002, 32'h00000001});
    end else begin
      $display("ok   direct_read_r3_r1: %h", rs_d_a);
    end

    // Writes to r0 are dropped.
    wr_a = 1'b1; rd_a = 5'd0; rd_d_a = 32'hDEADBEEF;
    rs_a = {5'd3, 5'd0};
    push(1, 0, 64'd0, "a_r0_before_edge");
    sample();
    step();
    wr_a = 1'b0;
    push(1, 0, 64'd0, "a_r0_after_edge");
    push(1, 1, 64'h2, "a_r3_unaffected");
    sample();

    // Same-cycle write/read hazard on r4.
    wr_a = 1'b1; rd_a = 5'd4; rd_d_a = 32'h11;
    step();
    rd_d_a = 32'h22;
    rs_a   = {5'd4, 5'd1};
`ifdef REG_FILE_BYPASS_EN
    push(1, 1, 64'h22, "a_hazard_before_edge");
`else
    push(1, 1, 64'h11, "a_hazard_before_edge");
`endif
    push(1, 0, 64'h1, "a_hazard_other_port");
    sample();
    step();
    wr_a = 1'b0;
    push(1, 1, 64'h22, "a_hazard_after_edge");
    sample();

    // Small instance: four independent ports.
    wr_b = 1'b1;
    rd_b = 3'd1; rd_d_b = 16'h1111; step();
    rd_b = 3'd2; rd_d_b = 16'h2222; step();
    rd_b = 3'd5; rd_d_b = 16'h5555; step();
    rd_b = 3'd7; rd_d_b = 16'h7777; step();
    wr_b = 1'b0;
    rs_b = {3'd7, 3'd5, 3'd2, 3'd1};
    push(3, 0, 64'h1111, "b_p0_r1");
    push(3, 1, 64'h2222, "b_p1_r2");
    push(3, 2, 64'h5555, "b_p2_r5");
    push(3, 3, 64'h7777, "b_p3_r7");
    sample();
    rs_b = {3'd1, 3'd2, 3'd5, 3'd7};
    push(3, 0, 64'h7777, "b_p0_r7");
    push(3, 1, 64'h5555, "b_p1_r5");
    push(3, 2, 64'h2222, "b_p2_r2");
    push(3, 3, 64'h1111, "b_p3_r1");
    sample();
    rs_b = {3'd5, 3'd0, 3'd5, 3'd5};
    push(3, 0, 64'h5555, "b_p0_same_r5");
    push(3, 1, 64'h5555, "b_p1_same_r5");
    push(3, 2, 64'h0000, "b_p2_r0");
    push(3, 3, 64'h5555, "b_p3_same_r5");
    sample();

    // Mid-run reset clears previously written registers.
    wr_a = 1'b1; rd_a = 5'd7; rd_d_a = 32'h77;
    step();
    wr_a = 1'b0;
    rs_a = {5'd1, 5'd7};
    push(1, 0, 64'h77, "a_read_r7");
    sample();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push(0, 0, 64'd0, "a_ready_after_midrun_reset");
    push(1, 0, 64'd0, "a_r7_in_clear");
    push(2, 0, 64'd0, "b_ready_after_midrun_reset");
    push(3, 0, 64'd0, "b_p0_in_clear");
    sample();
    if (ready_a !== 1'b0) begin
      n_miss++;
      $display("FAIL direct_ready_low_after_midrun_reset: got %b, expected 0", ready_a);
    end else begin
      $display("ok   direct_ready_low_after_midrun_reset: %b", ready_a);
    end
    for (int i = 1; i <= 31; i++) begin
      step();
      push(0, 0, (i == 31) ? 64'd1 : 64'd0, $sformatf("a_ready_resweep_edge%0d", i));
      push(2, 0, (i >= 7) ? 64'd1 : 64'd0, $sformatf("b_ready_resweep_edge%0d", i));
      sample();
    end
    push(1, 0, 64'd0, "a_r7_cleared");
    push(1, 1, 64'd0, "a_r1_cleared");
    push(3, 0, 64'd0, "b_r5_cleared_p0");
    push(3, 3, 64'd0, "b_r5_cleared_p3");
    sample();

    if (sb_q.size() != 0 || n_vec == 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d pending, %0d applied", sb_q.size(), n_vec);
    end else begin
      $display("ok   scoreboard_drain: %0d applied", n_vec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss != 0) begin
      $display("FAIL summary: %0d miscompares, expected 0", n_miss);
    end else begin
      $display("PASS summary: all checks passed");
    end
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the core register file. Adds a configurable data width, a configurable depth and 1–4 combinational read ports. Register 0 is hardwired to zero. After reset, a state machine sweeps every register to zero and signals completion on `ready`. Sits in the decode stage of the core, between instruction decode (register addresses) and the ALU/writeback path.

Parameters:
XLEN, 32, data width of each register in bits (8..64)
ADDR_W, 5, register address width; depth DEPTH = 2**ADDR_W (2..6)
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
rs  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rs_d  out  NUM_RD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd  in  ADDR_W  write address
rd_d  in  XLEN  write data
reg_wr  in  1  write enable, sampled on rising clk
ready  out  1  high when the clear sweep is done and writes are accepted

Behaviour:
- FSM states: CLEAR and RUN; cnt is an ADDR_W-bit sweep index.
- Reset (rst_n=0 at a rising edge): state=CLEAR, cnt=1, ready=0. Register array contents are not reset directly; the sweep clears them.
- CLEAR, each rising edge with rst_n=1:
  - reg[cnt] <= 0 and cnt <= cnt+1.
  - On the edge where cnt == DEPTH-1: state <= RUN and ready <= 1.
  - ready therefore goes high after exactly DEPTH-1 edges with rst_n=1 (31 for default parameters).
- CLEAR, other rules:
  - reg_wr is ignored; no user write is committed, and none is queued.
  - All rs_d ports are forced to 0.
- RUN:
  - A rising edge with reg_wr=1 and rd != 0 writes reg[rd] <= rd_d.
  - reg_wr=1 with rd=0 is a no-op.
  - ready stays 1.
- Reads are combinational, zero latency: rs_d[k] = reg[rs[k]], with rs[k]==0 always returning 0. Ports are fully independent, so identical addresses on several ports are legal.
- Same-cycle write and read of the same address (rd == rs[k] != 0, reg_wr=1): governed by REG_FILE_BYPASS_EN (see below).
- Reset asserted mid-sweep or in RUN:
  - Returns to CLEAR with cnt=1 and ready=0 at that edge.
  - The sweep restarts from register 1; previously written values are cleared.
- Width rules: rd_d is stored unmodified at XLEN bits; no sign handling or truncation.
- No X on outputs after the first reset edge; out-of-range addresses cannot occur (DEPTH = 2**ADDR_W).

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: write-through forwarding. In RUN, when reg_wr=1, rd != 0 and rs[k] == rd, rs_d[k] = rd_d in the same cycle (combinational). Other ports are unaffected. The array is still updated at the edge.
- Not defined: rs_d[k] returns the pre-edge stored value during the write cycle. The new value is visible only after the rising edge.
- In CLEAR the macro has no effect; outputs stay 0.

Test Plan:
1. Reset/sweep (default params): rst_n=0 for 2 edges, then 1 → ready=0 for 30 edges and 1 after the 31st edge; reading rs=5'h1F on port 0 gives 0.
2. Write/read: after ready, rd=1, rd_d=32'h00000001, reg_wr=1 for one edge; then rd=3, rd_d=32'h00000002 for one edge; set rs[0]=1, rs[1]=3 → rs_d = {32'h00000002, 32'h00000001}.
3. x0 protection: reg_wr=1, rd=0, rd_d=32'hDEADBEEF for one edge; rs[0]=0 → rs_d port 0 = 0 before and after the edge.
4. Write during sweep: reg_wr=1, rd=2, rd_d=32'hA5A5A5A5 throughout the sweep → after ready, reading rs=2 gives 0, and ports read 0 while ready=0.
5. Same-cycle hazard: reg[4]=32'h11; in one cycle reg_wr=1, rd=4, rd_d=32'h22, rs[1]=4 → rs_d port 1 = 32'h22 before the edge with REG_FILE_BYPASS_EN and 32'h11 without; 32'h22 after the edge in both builds.
6. Mid-run reset and params: write reg[7]=32'h77, pulse rst_n low one edge → ready=0, and after 31 edges ready=1 with reg[7]=0. Repeat with XLEN=16, ADDR_W=3, NUM_RD=4: ready after 7 edges, and all 4 ports independently read values written to regs 1,2,5,7.
